// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-synchronous double buffer.
// Optional SEG7_LEADING_ZERO_BLANK_EN darkens leading zero digits.
module seg7_scan_ctrl #(
   parameter int DIGITS    = 4,
   parameter int DIV       = 1000,
   parameter int BLANK_CYC = 16
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [4*DIGITS-1:0]   value,
   input  logic                  load,
   output logic                  update_pending,
   output logic                  frame_start,
   output logic [DIGITS-1:0]     dig_sel,
   output logic [6:0]            seg
);

   localparam int CW = $clog2(DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
   localparam logic [CW-1:0] BLANK   = CW'(BLANK_CYC);
   localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [4*DIGITS-1:0]   shadow_q, shadow_d;
   logic [4*DIGITS-1:0]   pending_q, pending_d;
   logic                  upd_q, upd_d;
   logic                  frame_start_q, frame_start_d;
   logic [DIGITS-1:0]     dig_sel_q, dig_sel_d;
   logic [6:0]            seg_q, seg_d;

   logic                  cnt_wrap;
   logic                  boundary;
   logic                  show;
   logic                  lz_blank;
   logic [3:0]            nib;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h58;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   // Counter/buffer next state; shadow only moves on the frame boundary.
   always_comb begin
      cnt_wrap  = (cnt_q == CNT_MAX);
      boundary  = cnt_wrap && (idx_q == IDX_MAX);
      cnt_d     = cnt_wrap ? '0 : cnt_q + 1'b1;
      idx_d     = idx_q;
      if (cnt_wrap) begin
         idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      end
      pending_d = load ? value : pending_q;
      shadow_d  = shadow_q;
      upd_d     = upd_q;
      if (boundary) begin
         upd_d = 1'b0;
         if (load) begin
            shadow_d = value;
         end else if (upd_q) begin
            shadow_d = pending_q;
         end
      end else if (load) begin
         upd_d = 1'b1;
      end
   end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   logic [DIGITS-1:0] zero_above;

   always_comb begin
      zero_above = '0;
      zero_above[DIGITS-1] = (shadow_q[4*(DIGITS-1) +: 4] == 4'h0);
      for (int i = DIGITS - 2; i >= 0; i--) begin
         zero_above[i] = zero_above[i+1] && (shadow_q[4*i +: 4] == 4'h0);
      end
      // Digit 0 stays lit so an all-zero value still reads "0".
      zero_above[0] = 1'b0;
      lz_blank = zero_above[idx_q];
   end
`else
   always_comb begin
      lz_blank = 1'b0;
   end
`endif

   always_comb begin
      nib           = 4'(shadow_q >> {idx_q, 2'b00});
      show          = (cnt_q >= BLANK);
      frame_start_d = (cnt_q == '0) && (idx_q == '0);
      dig_sel_d     = '0;
      seg_d         = '0;
      if (show) begin
         dig_sel_d = DIGITS'(1) << idx_q;
         seg_d     = lz_blank ? 7'h00 : hex7(nib);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cnt_q         <= '0;
         idx_q         <= '0;
         shadow_q      <= '0;
         pending_q     <= '0;
         upd_q         <= 1'b0;
         frame_start_q <= 1'b0;
         dig_sel_q     <= '0;
         seg_q         <= '0;
      end else begin
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         shadow_q      <= shadow_d;
         pending_q     <= pending_d;
         upd_q         <= upd_d;
         frame_start_q <= frame_start_d;
         dig_sel_q     <= dig_sel_d;
         seg_q         <= seg_d;
      end
   end

   assign update_pending = upd_q;
   assign frame_start    = frame_start_q;
   assign dig_sel        = dig_sel_q;
   assign seg            = seg_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DIGITS=4, DIV=8, BLANK_CYC=2.
// Honours SEG7_LEADING_ZERO_BLANK_EN in its expected segment values.
module tb_seg7_scan_ctrl;

   logic        clock;
   logic        reset_n;
   logic [15:0] value;
   logic        load;
   logic        update_pending;
   logic        frame_start;
   logic [3:0]  dig_sel;
   logic [6:0]  seg;

   int errors = 0;
   int checks = 0;
   int k = 0;

   seg7_scan_ctrl #(.DIGITS(4), .DIV(8), .BLANK_CYC(2)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .value          (value),
      .load           (load),
      .update_pending (update_pending),
      .frame_start    (frame_start),
      .dig_sel        (dig_sel),
      .seg            (seg)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [6:0] exp_seg(input logic [15:0] shad, input int slot);
      logic [6:0] tbl [16];
      logic [15:0] above;
      tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71};
      above = shad >> (4 * slot);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (slot > 0 && above == 16'h0) return 7'h00;
`endif
      return tbl[above[3:0]];
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s k=%0d got=%0h want=%0h", tag, k, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      k++;
   endtask

   // Output after edge k shows scan position k-1 of the free-running schedule.
   task automatic check_out(input logic [15:0] shad, input logic upd);
      int p, slot, c;
      logic [3:0] ed;
      logic [6:0] es;
      p    = k - 1;
      slot = (p / 8) % 4;
      c    = p % 8;
      ed   = 4'h0;
      es   = 7'h00;
      if (c >= 2) begin
         ed = 4'(1 << slot);
         es = exp_seg(shad, slot);
      end
      chk("dig_sel", 32'(dig_sel), 32'(ed));
      chk("seg", 32'(seg), 32'(es));
      chk("frame_start", 32'(frame_start), 32'(p % 32 == 0));
      chk("update_pending", 32'(update_pending), 32'(upd));
   endtask

   task automatic run_to(input int target, input logic [15:0] shad, input logic upd);
      while (k < target) begin
         tick();
         check_out(shad, upd);
      end
   endtask

   task automatic check_dark(input string tag);
      chk({tag, "_dig_sel"}, 32'(dig_sel), 32'h0);
      chk({tag, "_seg"}, 32'(seg), 32'h0);
      chk({tag, "_frame_start"}, 32'(frame_start), 32'h0);
      chk({tag, "_upd"}, 32'(update_pending), 32'h0);
   endtask

   initial begin
      reset_n = 1'b0;
      value   = 16'h0;
      load    = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock);
         #1;
         check_dark("reset");
      end
      reset_n = 1'b1;
      k = 0;

      run_to(10, 16'h0000, 1'b0);
      value = 16'h1234;
      load  = 1'b1;
      tick();
      check_out(16'h0000, 1'b1);
      load = 1'b0;
      run_to(31, 16'h0000, 1'b1);
      run_to(32, 16'h0000, 1'b0);
      run_to(40, 16'h1234, 1'b0);

      value = 16'hAAAA;
      load  = 1'b1;
      tick();
      check_out(16'h1234, 1'b1);
      load = 1'b0;
      run_to(50, 16'h1234, 1'b1);
      value = 16'h0F0F;
      load  = 1'b1;
      tick();
      check_out(16'h1234, 1'b1);
      load = 1'b0;
      run_to(63, 16'h1234, 1'b1);
      run_to(64, 16'h1234, 1'b0);
      run_to(95, 16'h0F0F, 1'b0);

      value = 16'h8888;
      load  = 1'b1;
      tick();
      check_out(16'h0F0F, 1'b0);
      load = 1'b0;
      run_to(129, 16'h8888, 1'b0);

      value = 16'h0070;
      load  = 1'b1;
      tick();
      check_out(16'h8888, 1'b1);
      load = 1'b0;
      run_to(159, 16'h8888, 1'b1);
      run_to(160, 16'h8888, 1'b0);
      run_to(194, 16'h0070, 1'b0);

      value = 16'h1111;
      load  = 1'b1;
      tick();
      check_out(16'h0070, 1'b1);
      load = 1'b0;
      run_to(211, 16'h0070, 1'b1);
      chk("mid_show_digit2", 32'(dig_sel), 32'h4);

      reset_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clock);
         #1;
         check_dark("midreset");
      end
      reset_n = 1'b1;
      k = 0;
      run_to(64, 16'h0000, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of common-select seven-segment digits sharing one segment bus. It sequences DIGITS hex nibbles onto the shared seg output, one digit per slot. Each slot has a blanking gap to suppress ghosting. New display values are double-buffered and take effect only at a frame boundary, so a frame never shows a torn value. It sits between the switch/button logic, which produces the value, and the board display pins.

Parameters:
DIGITS, 4, number of digits scanned; legal range 1..8.
DIV, 1000, clock cycles per digit slot; must exceed BLANK_CYC.
BLANK_CYC, 16, cycles at the start of each slot with display dark; legal range 1 to DIV-1.

Ports:
clock  in  1  system clock; all logic is on the rising edge.
reset_n  in  1  synchronous active-low reset.
value  in  4*DIGITS  digit i is value[4i+3:4i]; digit 0 is rightmost.
load  in  1  single-cycle strobe; captures value into the pending buffer.
update_pending  out  1  high while a captured value waits for the next frame boundary.
frame_start  out  1  one-cycle pulse on the first cycle of digit 0's slot.
dig_sel  out  DIGITS  one-hot, active-high digit enable; all zero while blanking.
seg  out  7  segments {g,f,e,d,c,b,a}, active high.

Behaviour:
- Reset is synchronous: while reset_n=0 at a clock edge, all of the following clear to 0: slot counter cnt, digit index idx, shadow register, pending register, update_pending, frame_start, dig_sel, seg.
- Reset mid-slot aborts the slot immediately. A pending load is discarded.
- cnt counts 0..DIV-1 and then wraps to 0. On each wrap, idx increments.
- idx wraps from DIGITS-1 to 0. Frame period is DIGITS*DIV cycles.
- Registered outputs, BLANK phase (cnt < BLANK_CYC): dig_sel=0 and seg=0.
- Registered outputs, SHOW phase (cnt >= BLANK_CYC): dig_sel=1<<idx and seg=decode(shadow nibble idx).
- After reset release, the first BLANK_CYC cycles are dark. dig_sel[0] then rises and stays high DIV-BLANK_CYC cycles.
- Decode, hex nibble to seg:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, B:7C, C:58, D:5E, E:79, F:71
- frame_start is high exactly for the cycle where cnt=0 and idx=0, once per frame. It is not asserted during reset.
- load=1: pending<=value and update_pending<=1. A later load in the same frame overwrites pending (last load wins).
- Frame boundary is the cycle at which cnt and idx both wrap to 0. At the boundary, if update_pending=1, then shadow<=pending and update_pending<=0.
- load coincident with a boundary: the value from that load goes directly to shadow, and update_pending stays 0.
- The shadow register never changes mid-frame.
- No other handshake exists. load is accepted every cycle and is never back-pressured.

Optional Feature:
SEG7_LEADING_ZERO_BLANK_EN
- Defined: shadow digits above the most significant nonzero nibble drive seg=0 during SHOW. Their dig_sel timing is unchanged.
- Digit 0 is always decoded, so a value of 0 shows a single "0".
- Blank mask is computed from shadow only, therefore it also changes only at frame boundaries.
- Undefined: every digit is decoded, including leading zeros.

Test Plan:
All scenarios use DIGITS=4, DIV=8, BLANK_CYC=2.
1. Reset: hold reset_n=0 for 5 cycles, then release -> dig_sel=0, seg=0, frame_start=0 during reset. After release, 2 dark cycles, then dig_sel=0001 and seg=3F for 6 cycles.
2. Slot sequence: free-run 64 cycles -> dig_sel steps 0001,0010,0100,1000, each high 6 cycles with 2-cycle gaps. frame_start pulses at cycles 0 and 32.
3. Load: load with value=1234 at cycle 10 -> update_pending=1 from cycle 11 to the boundary at cycle 32. Before the boundary, all digits show 3F. After the boundary, digits 0..3 show 66,4F,5B,06.
4. Two loads: value=AAAA at cycle 40, then value=0F0F at cycle 50 -> next frame shows 71,3F,71,3F. AAAA is never displayed.
5. Boundary collision: load value=8888 on the boundary cycle -> update_pending stays 0, and that frame shows 7F on all digits.
6. Reset mid-SHOW on digit 2 -> the next cycle has dig_sel=0 and seg=0. After release the display restarts at digit 0 showing 3F, and update_pending=0. With SEG7_LEADING_ZERO_BLANK_EN defined and value=0070, digits 3 and 2 show seg=00, digit 1 shows 07, and digit 0 shows 3F.
